// File: rtl/alu_issue.sv
// Decode/issue stage for RV32I OP, OP-IMM and LUI. It feeds the ALU through a
// registered output stage with one skid entry, so backpressure never loses or repeats work.
module alu_issue #(
    parameter int ALUCTRL_WIDTH = 4,
    parameter int XLEN          = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              instr_i,
    input  logic [XLEN-1:0]          rs1_data_i,
    input  logic [XLEN-1:0]          rs2_data_i,
    input  logic                     instr_valid_i,
    output logic                     instr_ready_o,
    output logic [XLEN-1:0]          alu_a_o,
    output logic [XLEN-1:0]          alu_b_o,
    output logic [ALUCTRL_WIDTH-1:0] aluctrl_o,
    output logic [4:0]               rd_o,
    output logic                     issue_valid_o,
    input  logic                     issue_ready_i,
    output logic                     illegal_o,
    output logic [7:0]               illegal_cnt_o
);

    localparam logic [6:0] OPC_REG = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0]          a;
        logic [XLEN-1:0]          b;
        logic [ALUCTRL_WIDTH-1:0] ctrl;
        logic [4:0]               rd;
    } issue_t;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    issue_t     dec;
    logic       legal;

    issue_t     out_q;
    logic       out_vld;
    issue_t     skid_q;
    logic       skid_vld;
    logic       ready_q;
    logic       illegal_q;
    logic [7:0] cnt;

    logic accept;
    logic out_fire;

    // Register indices are resolved upstream; only their data arrives here.
    logic unused_rs_idx;
    assign unused_rs_idx = ^instr_i[19:15];

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    always_comb begin
        dec   = '0;
        legal = 1'b0;
        case (opcode)
            OPC_REG: begin
                dec.a    = rs1_data_i;
                dec.b    = rs2_data_i;
                dec.ctrl = ALUCTRL_WIDTH'({f7[5], f3});
                dec.rd   = instr_i[11:7];
                legal    = (f7 == F7_ZERO) ||
                           ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_IMM: begin
                dec.a  = rs1_data_i;
                dec.b  = XLEN'($signed(instr_i[31:20]));
                dec.rd = instr_i[11:7];
                // Only the shift-right form uses f7 to pick arithmetic vs logical.
                if (f3 == 3'b101) begin
                    dec.ctrl = ALUCTRL_WIDTH'({f7[5], f3});
                    legal    = (f7 == F7_ZERO) || (f7 == F7_ALT);
                end else if (f3 == 3'b001) begin
                    dec.ctrl = ALUCTRL_WIDTH'({1'b0, f3});
                    legal    = (f7 == F7_ZERO);
                end else begin
                    dec.ctrl = ALUCTRL_WIDTH'({1'b0, f3});
                    legal    = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.a    = '0;
                dec.b    = XLEN'($signed({instr_i[31:12], 12'b0}));
                dec.ctrl = '0;
                dec.rd   = instr_i[11:7];
                legal    = 1'b1;
            end
            default: begin
                dec   = '0;
                legal = 1'b0;
            end
        endcase
    end

    assign accept   = instr_valid_i & ready_q;
    assign out_fire = out_vld & issue_ready_i;

    // ready_q drops in the same edge the skid entry fills, so the skid never overflows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_vld   <= 1'b0;
            skid_q    <= '0;
            skid_vld  <= 1'b0;
            ready_q   <= 1'b1;
            illegal_q <= 1'b0;
            cnt       <= 8'd0;
        end else begin
            illegal_q <= accept & ~legal;
            if (accept && !legal && (cnt != 8'hFF))
                cnt <= cnt + 8'd1;

            if (accept && legal) begin
                if (!out_vld || out_fire) begin
                    out_q   <= dec;
                    out_vld <= 1'b1;
                end else begin
                    skid_q   <= dec;
                    skid_vld <= 1'b1;
                    ready_q  <= 1'b0;
                end
            end else if (out_fire) begin
                if (skid_vld) begin
                    out_q    <= skid_q;
                    skid_vld <= 1'b0;
                    ready_q  <= 1'b1;
                end else begin
                    out_vld <= 1'b0;
                end
            end
        end
    end

    assign instr_ready_o = ready_q;
    assign issue_valid_o = out_vld;
    assign alu_a_o       = out_q.a;
    assign alu_b_o       = out_q.b;
    assign aluctrl_o     = out_q.ctrl;
    assign rd_o          = out_q.rd;
    assign illegal_o     = illegal_q;
    assign illegal_cnt_o = cnt;

endmodule
